// File: rtl/bip_pkg.sv
// -----------------------------------------------------------------------------
// bip_pkg
//   Shared definitions for the accumulator-processor control unit:
//   opcode encodings, FSM state encoding, accumulator-source (SelA)
//   encodings, the decoded control bundle and the opcode decoder.
// -----------------------------------------------------------------------------
package bip_pkg;

  localparam int PC_WIDTH    = 11;
  localparam int INSTR_WIDTH = 16;
  localparam int OPC_WIDTH   = INSTR_WIDTH - PC_WIDTH;

  // Opcode field, Instr[15:11]
  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  // Accumulator source select
  localparam logic [1:0] SELA_ALU = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_EXEC   = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  // Datapath / memory control lines produced during EXEC
  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       wr_acc;
    logic       op;
    logic       wr_ram;
    logic       rd_ram;
  } ctrl_t;

  // Opcode decoder. HLT and every unassigned opcode yield no strobes.
  function automatic ctrl_t decode_op(input logic [4:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_STO: c.wr_ram = 1'b1;
      OP_LD: begin
        c.rd_ram = 1'b1;
        c.sel_a  = SELA_MEM;
        c.wr_acc = 1'b1;
      end
      OP_LDI: begin
        c.sel_a  = SELA_IMM;
        c.wr_acc = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        c.rd_ram = 1'b1;
        c.sel_b  = 1'b1;
        c.op     = (opcode == OP_ADD);
        c.sel_a  = SELA_ALU;
        c.wr_acc = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        c.sel_b  = 1'b0;
        c.op     = (opcode == OP_ADDI);
        c.sel_a  = SELA_ALU;
        c.wr_acc = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bip_control_program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
//   W-bit program counter with increment and hold enables.
//   Wraps silently from all-ones to zero.
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset (count -> 0)
//   hold    in   freeze the count (overrides inc_en)
//   inc_en  in   advance the count by one
//   pc      out  current count
// -----------------------------------------------------------------------------
module program_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic         inc_en,
  output logic [W-1:0] pc
);

  logic [W-1:0] pc_reg;
  logic [W-1:0] pc_next;

  always_comb begin
    pc_next = pc_reg;
    if (!hold && inc_en) begin
      pc_next = pc_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= '0;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/bip_control.sv
// -----------------------------------------------------------------------------
// bip_control
//   Instruction-sequencing control unit for the accumulator processor.
//   Two-cycle FETCH/EXEC sequencing against a synchronous program memory,
//   absorbing HALTED state on HLT.
// Ports:
//   clk      in   system clock, rising edge
//   Reset_n  in   asynchronous active-low reset
//   Enable   in   run enable; low freezes state, PC and Addr, forces strobes 0
//   Instr    in   program-memory read data (valid one cycle after PC_Addr)
//   PC_Addr  out  program-memory read address
//   Addr     out  instruction operand field to datapath / data memory
//   SelA     out  accumulator source: 00 ALU, 01 immediate, 10 data memory
//   SelB     out  ALU operand B: 0 immediate, 1 data memory
//   WrAcc    out  accumulator write strobe
//   Op       out  ALU op: 1 add, 0 subtract
//   WrRam    out  data-memory write strobe
//   RdRam    out  data-memory read strobe
//   Halt     out  high once HLT has executed
//   Cycles   out  (only with BIP_CTRL_CYCLE_COUNT_EN) enabled-cycle count,
//                 frozen once halted, saturating at 0xFFFF
// Build option: define BIP_CTRL_CYCLE_COUNT_EN to add the Cycles counter.
// -----------------------------------------------------------------------------
module bip_control
  import bip_pkg::*;
#(
  parameter int PC_W    = 11,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               Reset_n,
  input  logic               Enable,
  input  logic [INSTR_W-1:0] Instr,
  output logic [PC_W-1:0]    PC_Addr,
  output logic [PC_W-1:0]    Addr,
  output logic [1:0]         SelA,
  output logic               SelB,
  output logic               WrAcc,
  output logic               Op,
  output logic               WrRam,
  output logic               RdRam,
  output logic               Halt
`ifdef BIP_CTRL_CYCLE_COUNT_EN
  ,
  output logic [15:0]        Cycles
`endif
);

  state_t          state_reg;
  state_t          state_next;
  ctrl_t           ctrl;
  logic            pc_inc;
  logic            addr_load;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] addr_reg;
  logic [4:0]      opcode;
  logic [PC_W-1:0] operand;

  assign opcode  = Instr[INSTR_W-1:PC_W];
  assign operand = Instr[PC_W-1:0];

  // ---------------------------------------------------------------------------
  // Next-state / output logic. Everything is gated by Enable so that a
  // disabled cycle leaves state, PC and Addr untouched and all strobes low.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    ctrl       = '0;
    pc_inc     = 1'b0;
    addr_load  = 1'b0;
    if (Enable) begin
      case (state_reg)
        ST_FETCH: state_next = ST_EXEC;
        ST_EXEC: begin
          ctrl      = decode_op(opcode);
          addr_load = 1'b1;
          if (opcode == OP_HLT) begin
            state_next = ST_HALTED;
          end else begin
            pc_inc     = 1'b1;
            state_next = ST_FETCH;
          end
        end
        ST_HALTED: state_next = ST_HALTED;
        default:   state_next = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= ST_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Operand register: captured at the end of each executed instruction and
  // held until the next one.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_reg <= '0;
    end else if (addr_load) begin
      addr_reg <= operand;
    end
  end

  program_counter #(
    .W(PC_W)
  ) u_pc (
    .clk    (clk),
    .rst_n  (Reset_n),
    .hold   (!Enable),
    .inc_en (pc_inc),
    .pc     (pc)
  );

  // During an enabled EXEC the memory strobes are combinational, so the
  // operand is forwarded straight from Instr to keep the address aligned
  // with the strobe it qualifies; otherwise the captured value is shown.
  assign Addr    = addr_load ? operand : addr_reg;
  assign PC_Addr = pc;
  assign SelA    = ctrl.sel_a;
  assign SelB    = ctrl.sel_b;
  assign WrAcc   = ctrl.wr_acc;
  assign Op      = ctrl.op;
  assign WrRam   = ctrl.wr_ram;
  assign RdRam   = ctrl.rd_ram;
  assign Halt    = (state_reg == ST_HALTED);

`ifdef BIP_CTRL_CYCLE_COUNT_EN
  logic [15:0] cycles_reg;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cycles_reg <= '0;
    end else if (Enable && (state_reg != ST_HALTED) && (cycles_reg != 16'hFFFF)) begin
      cycles_reg <= cycles_reg + 16'd1;
    end
  end

  assign Cycles = cycles_reg;
`endif

endmodule
